// File: rtl/addsub_pkg.sv
// Shared definitions for the serial add/subtract unit: op encodings and FSM states.
package addsub_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_INC = 2'b10;
  localparam logic [OP_W-1:0] OP_DEC = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its top bit
// so the caller can derive signed overflow on the final chunk.
module adder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout    = c[CHUNK];
  assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract unit: one CHUNK-wide adder is reused over WIDTH/CHUNK
// cycles, with valid/ready handshakes on request and result.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("addsub_serial: WIDTH must be a multiple of CHUNK");
  end

  state_t           state, state_next;
  logic [KW-1:0]    k, k_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             cy, cy_next;
  logic [WIDTH-1:0] result_next, res_work;
  logic             carry_next, overflow_next, zero_next;
  logic             sub;
  int unsigned      base;

  logic [CHUNK-1:0] sum;
  logic             cout, msb_cin;

  assign base = 32'(k) * CHUNK;
  assign sub  = (op == OP_SUB) || (op == OP_DEC);

  adder_chunk #(.CHUNK(CHUNK)) u_adder (
    .a       (a_reg[base +: CHUNK]),
    .b       (b_reg[base +: CHUNK]),
    .cin     (cy),
    .sum     (sum),
    .cout    (cout),
    .msb_cin (msb_cin)
  );

  // Reset holds off acceptance even though the state register already reads IDLE.
  assign in_ready = rst_n && (state == IDLE);

  // Next-state and datapath update.
  always_comb begin
    state_next    = state;
    k_next        = k;
    a_next        = a_reg;
    b_next        = b_reg;
    cy_next       = cy;
    result_next   = result;
    carry_next    = carry;
    overflow_next = overflow;
    zero_next     = zero;
    res_work      = result;
    res_work[base +: CHUNK] = sum;

    case (state)
      IDLE: begin
        if (in_valid) begin
          a_next     = a;
          b_next     = (((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b) ^ {WIDTH{sub}};
          cy_next    = sub;
          k_next     = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        result_next = res_work;
        cy_next     = cout;
        if (k == K_LAST) begin
          carry_next    = cout;
          overflow_next = msb_cin ^ cout;
          zero_next     = (res_work == '0);
          k_next        = '0;
          state_next    = DONE;
        end else begin
          k_next = k + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      cy        <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      k         <= k_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      cy        <= cy_next;
      result    <= result_next;
      carry     <= carry_next;
      overflow  <= overflow_next;
      zero      <= zero_next;
      out_valid <= (state_next == DONE);
    end
  end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle add/subtract unit that processes a WIDTH-bit operation CHUNK bits per clock. It uses a valid/ready handshake on both input and output, supports four ops (ADD, SUB, INC, DEC) and reports carry, signed overflow and zero flags. It sits in the datapath where the cell and pointer arithmetic needs a narrow, area-cheap adder. Area is traded for latency: one CHUNK-wide adder is reused across WIDTH/CHUNK cycles.

## Interface
Parameters:
- WIDTH, 16, operand/result width.
- CHUNK, 4, bits processed per cycle. WIDTH % CHUNK != 0 is an elaboration error. N = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (ignored for INC/DEC).
- op  in  2  00 ADD a+b, 01 SUB a-b, 10 INC a+1, 11 DEC a-1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- carry  out  1  carry out of the MSB (for SUB/DEC: 1 = no borrow).
- overflow  out  1  signed overflow (carry into MSB XOR carry out of MSB).
- zero  out  1  result == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE.** in_ready=1. On in_valid, latch the operands:
  - A_reg=a.
  - B_reg = b for ADD/SUB, or WIDTH'(1) for INC/DEC.
  - sub=op[0]; B_reg is XORed with {WIDTH{sub}}.
  - Carry register is set to sub.
  - Chunk index k=0. Go to RUN.
- **RUN.** Each cycle, add chunk k of A_reg and B_reg with the carry register.
  - Write the CHUNK-bit sum into result bits [k*CHUNK +: CHUNK] and update the carry register.
  - Record the carry into the MSB when k = N-1. Increment k.
  - After chunk N-1, capture carry, overflow and zero, then go to DONE.
- **DONE.** out_valid=1. result and flags are held stable until out_ready=1, then go to IDLE.
- in_ready=0 in RUN and DONE; requests are never overlapped.
- Flags and result are valid only while out_valid=1. Their contents at other times are unspecified except after reset.

## Timing
- Acceptance at edge T (in_valid & in_ready). out_valid rises after edge T+N. Latency is N cycles; N=1 when CHUNK=WIDTH.
- Output handshake completes at the edge where out_valid & out_ready; out_valid falls after that edge.
- Minimum issue period is N+2 cycles: accept, N RUN cycles, DONE, back to IDLE.
- out_ready held low: state stays DONE indefinitely, outputs bit-stable, in_ready=0.
- in_valid while busy: ignored; the requester must hold it until in_ready=1.
- Reset values (rst_n=0 at an edge):
  - State=IDLE; out_valid=0; result=0; carry=0; overflow=0; zero=0; k=0.
  - in_ready is forced to 0 while rst_n=0 and is 1 on the first cycle after rst_n rises.
- Reset mid-RUN or mid-DONE: the operation is abandoned and no out_valid is produced.
- Wrap-around: results are modulo 2^WIDTH. 0xFFFF+1 gives result 0 with carry=1.

## Structure
- Shared package `addsub_pkg`: op encoding constants (OP_ADD, OP_SUB, OP_INC, OP_DEC) and the FSM state enum.
- Sub-module `adder_chunk` (parameter CHUNK): combinational ripple adder with inputs a, b and cin, and outputs sum, cout and msb_cin. It is instantiated once; FSM and registers live in the top module.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
- ADD 0x00FF + 0x0101 -> result 0x0200, carry=0, overflow=0, zero=0. out_valid exactly 4 cycles after acceptance.
- SUB 0x0010 - 0x0008 -> 0x0008, carry=1. SUB 0x0008 - 0x0010 -> 0xFFF8, carry=0.
- INC 0x7FFF -> 0x8000, overflow=1. DEC 0x0000 -> 0xFFFF, carry=0, overflow=0. ADD 0xFFFF + 0x0001 -> 0x0000, carry=1, zero=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE: result and flags stable, in_ready=0, and an in_valid pulse is ignored.
  - Release out_ready: IDLE on the next cycle, and the next request is accepted.
- Reset mid-RUN: assert rst_n=0 at chunk 2. Next cycle out_valid=0, result=0, flags=0, and no result ever appears. After release, in_ready=1 and a new ADD completes correctly.
- Parameter sweep: with CHUNK=16 (N=1) and with WIDTH=8, CHUNK=2 (N=4), run 1000 random ops against a reference model. Check result/carry/overflow/zero and that the latency is exactly N.
